// File: rtl/div_sched.sv
// Shares NUM_DIV divider units among NUM_REQ requesters: round-robin job intake,
// lowest-free-unit dispatch, round-robin tagged result return.
module div_sched #(
  parameter int  NUM_REQ = 4,
  parameter int  NUM_DIV = 2,
  parameter int  WIDTH   = 32,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_DIV-1:0]       div_start,
  output logic [NUM_DIV*WIDTH-1:0] div_x,
  output logic [NUM_DIV*WIDTH-1:0] div_y,
  input  logic [NUM_DIV-1:0]       div_valid,
  input  logic [NUM_DIV*WIDTH-1:0] div_q,
  input  logic [NUM_DIV*WIDTH-1:0] div_r,
  input  logic [NUM_DIV-1:0]       div_dbz,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
  output logic                     rsp_dbz,
  output logic [NUM_DIV-1:0]       units_busy
);
  localparam int UIW = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} unit_state_t;

  logic [WIDTH-1:0]   x_arr   [NUM_REQ];
  logic [WIDTH-1:0]   y_arr   [NUM_REQ];
  logic [IDW-1:0]     tag_arr [NUM_DIV];
  logic [WIDTH-1:0]   q_arr   [NUM_DIV];
  logic [WIDTH-1:0]   r_arr   [NUM_DIV];
  logic [NUM_DIV-1:0] dbz_vec, idle, done, load, pop;

  logic [IDW-1:0]   rr_req, gnt_id, req_cand;
  logic [UIW-1:0]   rr_rsp, free_unit, rsp_unit, rsp_cand;
  logic             gnt_found, rsp_hit, req_fire, rsp_fire;
  logic [WIDTH-1:0] gnt_x, gnt_y;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign x_arr[i] = req_x[i*WIDTH +: WIDTH];
    assign y_arr[i] = req_y[i*WIDTH +: WIDTH];
  end

  // Intake: first valid requester at or after rr_req, only while some unit is idle.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    req_cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      req_cand = IDW'((int'(rr_req) + off) % NUM_REQ);
      if (!gnt_found && req_valid[req_cand]) begin
        gnt_found = 1'b1;
        gnt_id    = req_cand;
      end
    end
  end

  always_comb begin
    free_unit = '0;
    for (int k = NUM_DIV - 1; k >= 0; k--) begin
      if (idle[UIW'(k)]) free_unit = UIW'(k);
    end
  end

  assign req_fire  = gnt_found && (|idle);
  assign req_ready = req_fire ? (NUM_REQ'(1) << gnt_id) : '0;
  assign gnt_x     = x_arr[gnt_id];
  assign gnt_y     = y_arr[gnt_id];

  // Return: first DONE unit at or after rr_rsp drives the response fields.
  always_comb begin
    rsp_hit  = 1'b0;
    rsp_unit = '0;
    rsp_cand = '0;
    for (int off = 0; off < NUM_DIV; off++) begin
      rsp_cand = UIW'((int'(rr_rsp) + off) % NUM_DIV);
      if (!rsp_hit && done[rsp_cand]) begin
        rsp_hit  = 1'b1;
        rsp_unit = rsp_cand;
      end
    end
  end

  assign rsp_valid  = rsp_hit;
  assign rsp_fire   = rsp_hit && rsp_ready;
  assign rsp_id     = tag_arr[rsp_unit];
  assign rsp_q      = q_arr[rsp_unit];
  assign rsp_r      = r_arr[rsp_unit];
  assign rsp_dbz    = dbz_vec[rsp_unit];
  assign units_busy = ~idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_req <= '0;
      rr_rsp <= '0;
    end else begin
      if (req_fire) rr_req <= IDW'((int'(gnt_id) + 1) % NUM_REQ);
      if (rsp_fire) rr_rsp <= UIW'((int'(rsp_unit) + 1) % NUM_DIV);
    end
  end

  for (genvar k = 0; k < NUM_DIV; k++) begin : g_unit
    unit_state_t      state, state_nxt;
    logic [IDW-1:0]   tag;
    logic [WIDTH-1:0] op_x, op_y, res_q, res_r;
    logic             res_dbz;

    assign load[k] = req_fire && (free_unit == UIW'(k));
    assign pop[k]  = rsp_fire && (rsp_unit == UIW'(k));

    always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
    end

    // A zero divisor never reaches the divider; the unit completes immediately.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (load[k]) state_nxt = (gnt_y == '0) ? DONE : ISSUE;
        ISSUE:   state_nxt = RUN;
        RUN:     if (div_valid[k]) state_nxt = DONE;
        DONE:    if (pop[k]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tag     <= '0;
        op_x    <= '0;
        op_y    <= '0;
        res_q   <= '0;
        res_r   <= '0;
        res_dbz <= 1'b0;
      end else if (load[k]) begin
        tag  <= gnt_id;
        op_x <= gnt_x;
        op_y <= gnt_y;
        if (gnt_y == '0) begin
          res_q   <= '0;
          res_r   <= '0;
          res_dbz <= 1'b1;
        end
      end else if (state == RUN && div_valid[k]) begin
        res_q   <= div_q[k*WIDTH +: WIDTH];
        res_r   <= div_r[k*WIDTH +: WIDTH];
        res_dbz <= div_dbz[k];
      end
    end

    assign idle[k]                   = (state == IDLE);
    assign done[k]                   = (state == DONE);
    assign div_start[k]              = (state == ISSUE);
    assign div_x[k*WIDTH +: WIDTH]   = op_x;
    assign div_y[k*WIDTH +: WIDTH]   = op_y;
    assign tag_arr[k]                = tag;
    assign q_arr[k]                  = res_q;
    assign r_arr[k]                  = res_r;
    assign dbz_vec[k]                = res_dbz;
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus randomized traffic, with a divider
// model and a scoreboard of expected (id, q, r, dbz) results.
module tb_div_sched;
  localparam int NR  = 4;
  localparam int ND  = 2;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_x = '0;
  logic [NR*W-1:0] req_y = '0;
  logic [ND-1:0]   div_start;
  logic [ND*W-1:0] div_x, div_y;
  logic [ND-1:0]   div_valid = '0;
  logic [ND*W-1:0] div_q = '0;
  logic [ND*W-1:0] div_r = '0;
  logic [ND-1:0]   div_dbz = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_q, rsp_r;
  logic            rsp_dbz;
  logic [ND-1:0]   units_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sched #(.NUM_REQ(NR), .NUM_DIV(ND), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_valid(div_valid), .div_q(div_q), .div_r(div_r), .div_dbz(div_dbz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .units_busy(units_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Divider model: result valid L cycles after the start cycle, L>=1.
  int         lat [ND];
  bit         rand_lat = 1'b0;
  bit         run [ND];
  bit         stale [ND];
  int         rem [ND];
  logic [W-1:0] mx [ND];
  logic [W-1:0] my [ND];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < ND; k++) begin
      div_valid[k] = 1'b0;
      if (run[k]) begin
        rem[k]--;
        if (rem[k] == 0) begin
          run[k] = 1'b0;
          div_valid[k] = 1'b1;
          div_q[k*W +: W] = (my[k] == 0) ? '0 : mx[k] / my[k];
          div_r[k*W +: W] = (my[k] == 0) ? '0 : mx[k] % my[k];
          div_dbz[k] = 1'b0;
          if (!stale[k]) begin
            check("op_x_stable", div_x[k*W +: W], mx[k]);
            check("op_y_stable", div_y[k*W +: W], my[k]);
          end
        end
      end
      if (div_start[k] === 1'b1) begin
        check("start_y_nonzero", (div_y[k*W +: W] != 0), 1'b1);
        run[k]   = 1'b1;
        stale[k] = 1'b0;
        mx[k]    = div_x[k*W +: W];
        my[k]    = div_y[k*W +: W];
        rem[k]   = rand_lat ? int'($urandom_range(1, 6)) : lat[k];
      end
    end
  end

  // Scoreboard: accepted jobs become expected results; arbitration rules checked each cycle.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
  } exp_t;

  exp_t          sb[$];
  exp_t          ent;
  int            outstanding = 0;
  int            ptr = 0;
  logic [NR-1:0] mon_exp;
  bit            mon_found, mon_acc;
  int            mon_idx;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      outstanding = 0;
      ptr = 0;
      for (int k = 0; k < ND; k++) if (run[k]) stale[k] = 1'b1;
    end else begin
      mon_exp = '0;
      if (outstanding < ND) begin
        for (int off = 0; off < NR; off++) begin
          if (mon_exp == '0 && req_valid[(ptr + off) % NR]) mon_exp[(ptr + off) % NR] = 1'b1;
        end
      end
      check("req_ready_grant", req_ready, mon_exp);
      check("busy_count", $countones(units_busy), outstanding);
      mon_acc = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ent.id = IDW'(i);
          if (req_y[i*W +: W] == 0) begin
            ent.q = '0; ent.r = '0; ent.dbz = 1'b1;
          end else begin
            ent.q   = req_x[i*W +: W] / req_y[i*W +: W];
            ent.r   = req_x[i*W +: W] % req_y[i*W +: W];
            ent.dbz = 1'b0;
          end
          sb.push_back(ent);
          ptr = (i + 1) % NR;
          mon_acc = 1'b1;
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        mon_found = 1'b0;
        mon_idx = 0;
        foreach (sb[j]) begin
          if (!mon_found && sb[j].id === rsp_id && sb[j].q === rsp_q &&
              sb[j].r === rsp_r && sb[j].dbz === rsp_dbz) begin
            mon_found = 1'b1;
            mon_idx = j;
          end
        end
        check("rsp_in_scoreboard", mon_found, 1'b1);
        if (mon_found) sb.delete(mon_idx);
        outstanding--;
      end
      if (mon_acc) outstanding++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    check(tag, rsp_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((units_busy != '0 || rsp_valid) && n < 100);
    check(tag, units_busy, '0);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int n, viol;
    logic [NR-1:0] acc;
    lat[0] = 5;
    lat[1] = 5;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_div_start", div_start, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_units_busy", units_busy, '0);
    check("rst_div_x", div_x, '0);
    check("rst_div_y", div_y, '0);

    // Single job: 100/7 from requester 2
    tick();
    set_req(2, 100, 7);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_start", div_start, 2'b01);
    check("single_div_x", div_x[0 +: W], 100);
    check("single_div_y", div_y[0 +: W], 7);
    wait_rsp("single_rsp_valid", n);
    check("single_latency", 1 + n, 7);
    check("single_id", rsp_id, 2);
    check("single_q", rsp_q, 14);
    check("single_r", rsp_r, 2);
    check("single_dbz", rsp_dbz, 1'b0);

    // Zero divisor: 55/0 from requester 1
    tick();
    set_req(1, 55, 0);
    req_valid = 4'b0010;
    @(negedge clk);
    check("zd_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("zd_rsp_valid", rsp_valid, 1'b1);
    check("zd_no_start", div_start, '0);
    check("zd_id", rsp_id, 1);
    check("zd_q", rsp_q, 0);
    check("zd_r", rsp_r, 0);
    check("zd_dbz", rsp_dbz, 1'b1);

    // Backpressure: both units fill while responses are held
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat[0] = 2;
    lat[1] = 2;
    rsp_ready = 1'b0;
    set_req(0, 1000, 10);
    set_req(1, 77, 5);
    req_valid = 4'b0011;
    @(negedge clk);
    check("bp_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    check("bp_grant1", req_ready, 4'b0010);
    tick();
    set_req(2, 20, 6);
    req_valid = 4'b0100;
    repeat (6) @(negedge clk);
    check("bp_busy", units_busy, 2'b11);
    check("bp_full_ready", req_ready, '0);
    check("bp_rsp_held", rsp_valid, 1'b1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain0_id", rsp_id, 0);
    check("bp_drain0_q", rsp_q, 100);
    check("bp_no_same_cycle_reuse", req_ready, '0);
    tick();
    @(negedge clk);
    check("bp_drain1_id", rsp_id, 1);
    check("bp_drain1_q", rsp_q, 15);
    check("bp_drain1_r", rsp_r, 2);
    check("bp_reuse_next_cycle", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_idle("bp_drain_idle");

    // Out-of-order completion: slow unit 0, fast unit 1
    lat[0] = 10;
    lat[1] = 3;
    tick();
    set_req(3, 50, 3);
    set_req(2, 9, 4);
    req_valid = 4'b1100;
    @(negedge clk);
    check("ooo_grant0", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("ooo_grant1", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp("ooo_first_valid", n);
    check("ooo_first_id", rsp_id, 2);
    check("ooo_first_q", rsp_q, 2);
    check("ooo_first_r", rsp_r, 1);
    tick();
    wait_rsp("ooo_second_valid", n);
    check("ooo_second_id", rsp_id, 3);
    check("ooo_second_q", rsp_q, 16);
    check("ooo_second_r", rsp_r, 2);

    // Reset while unit 0 is running; its late result must vanish
    lat[0] = 8;
    tick();
    set_req(1, 40, 3);
    req_valid = 4'b0010;
    @(negedge clk);
    check("rm_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || units_busy !== '0) viol++;
    end
    check("rm_no_response", viol, 0);
    tick();
    for (int i = 0; i < NR; i++) set_req(i, 30 + i, 3);
    req_valid = 4'b1111;
    @(negedge clk);
    check("rm_grant_req0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("rm_start_unit0", div_start, 2'b01);
    wait_idle("rm_drain_idle");

    // Randomized traffic with random backpressure and divider latency
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rand_lat = 1'b1;
    acc = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0)      set_req(i, $urandom, 0);
          else if ($urandom_range(0, 1) == 0) set_req(i, $urandom, $urandom_range(1, 20));
          else                                set_req(i, $urandom, $urandom);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain_idle");
    check("rand_scoreboard_empty", sb.size(), 0);
    check("rand_outstanding_zero", outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
